// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the I-cache refill controller and its neighbours:
// the lookup stage, the tag/valid arrays, the replacement block and the
// L2/memory port. The controller takes the master side.
interface icache_refill_ctrl_if #(
  parameter int N_WAY  = 4,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 512,
  parameter int OFF_W  = 6
);
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

  // lookup-miss request
  logic              miss_valid_i;
  logic              miss_ready_o;
  logic [IDX_W-1:0]  miss_idx_i;
  logic [TAG_W-1:0]  miss_tag_i;
  logic              kill_i;

  // valid array read
  logic              valid_rd_en_o;
  logic [IDX_W-1:0]  valid_rd_idx_o;
  logic [N_WAY-1:0]  valid_vec_i;

  // replacement block
  logic [N_WAY-1:0]  repl_valid_vec_o;
  logic              update_repl_o;
  logic [N_WAY-1:0]  replace_vec_i;

  // next-level memory port
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [LINE_W-1:0] mem_rsp_data_i;
  logic              mem_rsp_err_i;

  // data/tag/valid array write and completion status
  logic              wr_en_o;
  logic [N_WAY-1:0]  wr_way_o;
  logic [IDX_W-1:0]  wr_idx_o;
  logic [TAG_W-1:0]  wr_tag_o;
  logic [LINE_W-1:0] wr_data_o;
  logic              refill_done_o;
  logic              refill_err_o;

  modport master (
    input  miss_valid_i, miss_idx_i, miss_tag_i, kill_i,
    input  valid_vec_i, replace_vec_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    output miss_ready_o, valid_rd_en_o, valid_rd_idx_o,
    output repl_valid_vec_o, update_repl_o,
    output mem_req_valid_o, mem_req_addr_o,
    output wr_en_o, wr_way_o, wr_idx_o, wr_tag_o, wr_data_o,
    output refill_done_o, refill_err_o
  );

  modport slave (
    output miss_valid_i, miss_idx_i, miss_tag_i, kill_i,
    output valid_vec_i, replace_vec_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    input  miss_ready_o, valid_rd_en_o, valid_rd_idx_o,
    input  repl_valid_vec_o, update_repl_o,
    input  mem_req_valid_o, mem_req_addr_o,
    input  wr_en_o, wr_way_o, wr_idx_o, wr_tag_o, wr_data_o,
    input  refill_done_o, refill_err_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache L1 line refill sequencer. Accepts one lookup miss at a time,
// reads the set's valid vector, lets the replacement block pick a victim,
// fetches the line from the next level and writes data+tag into that way.
// A kill (pipeline flush) aborts early, or once the memory request has been
// accepted, drains the outstanding response without writing it.
module icache_refill_ctrl #(
  parameter int N_WAY  = 4,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 512,
  parameter int OFF_W  = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  icache_refill_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_VALID,
    S_SEL_WAY,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WRITE
  } state_e;

  state_e            state_reg;
  state_e            state_next;

  logic [IDX_W-1:0]  idx_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [N_WAY-1:0]  way_reg;
  logic [LINE_W-1:0] data_reg;
  logic              drop_reg;

  logic [N_WAY-1:0]  way_pick;
  logic              rsp_accept;
  logic              write_active;

  // Victim way reduced to its lowest set bit; an all-zero vector falls back
  // to way 0, so the write strobe never sees a zero or multi-hot way.
  always_comb begin
    logic found;
    way_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (bus.replace_vec_i[i] && !found) begin
        way_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      way_pick[0] = 1'b1;
    end
  end

  // A response is turned into a write only if the refill was not killed
  // earlier, is not being killed now, and carries no bus error.
  assign rsp_accept = bus.mem_rsp_valid_i && !drop_reg && !bus.kill_i && !bus.mem_rsp_err_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: kill aborts before the handshake, drains after it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.miss_valid_i) begin
          state_next = S_RD_VALID;
        end
      end
      S_RD_VALID: begin
        state_next = bus.kill_i ? S_IDLE : S_SEL_WAY;
      end
      S_SEL_WAY: begin
        state_next = bus.kill_i ? S_IDLE : S_MEM_REQ;
      end
      S_MEM_REQ: begin
        // Once the request is accepted the response must be drained, so a
        // same-cycle kill only marks the refill as dropped.
        if (bus.mem_req_ready_i) begin
          state_next = S_MEM_WAIT;
        end else if (bus.kill_i) begin
          state_next = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          state_next = rsp_accept ? S_WRITE : S_IDLE;
        end
      end
      S_WRITE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Refill context: request fields, victim way, line data and drop flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_reg  <= '0;
      tag_reg  <= '0;
      way_reg  <= '0;
      data_reg <= '0;
      drop_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          drop_reg <= 1'b0;
          if (bus.miss_valid_i) begin
            idx_reg <= bus.miss_idx_i;
            tag_reg <= bus.miss_tag_i;
          end
        end
        S_MEM_REQ: begin
          if (bus.mem_req_ready_i) begin
            way_reg  <= way_pick;
            drop_reg <= bus.kill_i;
          end
        end
        S_MEM_WAIT: begin
          if (bus.mem_rsp_valid_i) begin
            drop_reg <= 1'b0;
            if (rsp_accept) begin
              data_reg <= bus.mem_rsp_data_i;
            end
          end else if (bus.kill_i) begin
            drop_reg <= 1'b1;
          end
        end
        default: begin
          drop_reg <= drop_reg;
        end
      endcase
    end
  end

  assign write_active = (state_reg == S_WRITE);

  // Output decode: every strobe and bus field is zero outside its own state.
  always_comb begin
    bus.miss_ready_o     = (state_reg == S_IDLE);
    bus.valid_rd_en_o    = (state_reg == S_RD_VALID);
    bus.valid_rd_idx_o   = (state_reg == S_RD_VALID) ? idx_reg : '0;
    bus.update_repl_o    = (state_reg == S_SEL_WAY);
    bus.repl_valid_vec_o = (state_reg == S_SEL_WAY) ? bus.valid_vec_i : '0;
    bus.mem_req_valid_o  = (state_reg == S_MEM_REQ);
    bus.mem_req_addr_o   = (state_reg == S_MEM_REQ) ? {tag_reg, idx_reg, {OFF_W{1'b0}}} : '0;
    bus.refill_err_o     = (state_reg == S_MEM_WAIT) && bus.mem_rsp_valid_i && bus.mem_rsp_err_i
                           && !drop_reg && !bus.kill_i;
    bus.wr_en_o          = write_active;
    bus.wr_idx_o         = write_active ? idx_reg : '0;
    bus.wr_tag_o         = write_active ? tag_reg : '0;
    bus.wr_data_o        = write_active ? data_reg : '0;
    bus.refill_done_o    = write_active;
  end

  // Per-way write select, gated so it is quiet whenever no write is issued.
  generate
    for (genvar gi = 0; gi < N_WAY; gi++) begin : g_wr_way
      assign bus.wr_way_o[gi] = write_active & way_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a table of complete refills plus
// hand-written kill and mid-refill reset sequences. A small replacement
// model (lowest invalid way, else round-robin) stands in for the real block.
module tb_icache_refill_ctrl;

  logic clk_i;
  logic rst_i;

  icache_refill_ctrl_if #(.N_WAY(4), .IDX_W(6), .TAG_W(20), .LINE_W(512), .OFF_W(6)) bus ();

  icache_refill_ctrl #(.N_WAY(4), .IDX_W(6), .TAG_W(20), .LINE_W(512), .OFF_W(6)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [19:0] tag;
    logic [3:0]  vvec;
    int          stall;
    int          delay;
    logic        err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_way;
    int          exp_lat;
  } vec_t;

  vec_t tbl [7];

  // Replacement block model.
  logic [1:0] rr_ptr;

  function automatic logic [3:0] lowest_invalid(input logic [3:0] v);
    logic [3:0] r;
    logic       found;
    r = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i] && !found) begin
        r = 4'b0001 << i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= 2'd0;
      bus.replace_vec_i <= 4'b0001;
    end else if (bus.update_repl_o) begin
      if (&bus.repl_valid_vec_o) begin
        bus.replace_vec_i <= 4'b0001 << rr_ptr;
        rr_ptr <= rr_ptr + 2'd1;
      end else begin
        bus.replace_vec_i <= lowest_invalid(bus.repl_valid_vec_o);
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.miss_valid_i    = 1'b0;
    bus.miss_idx_i      = '0;
    bus.miss_tag_i      = '0;
    bus.kill_i          = 1'b0;
    bus.valid_vec_i     = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.mem_rsp_err_i   = 1'b0;
  endtask

  // Accept a miss and walk to the MEM_REQ cycle; returns at that negedge.
  task automatic to_mem_req(input logic [5:0] idx, input logic [19:0] tag,
                            input logic [3:0] vvec, input string tn);
    @(negedge clk_i);
    bus.miss_valid_i = 1'b1;
    bus.miss_idx_i   = idx;
    bus.miss_tag_i   = tag;
    #1 chk({tn, ".miss_ready"}, 512'(bus.miss_ready_o), 512'd1);
    @(negedge clk_i);
    bus.miss_valid_i = 1'b0;
    #1;
    chk({tn, ".rd_en"}, 512'(bus.valid_rd_en_o), 512'd1);
    chk({tn, ".rd_idx"}, 512'(bus.valid_rd_idx_o), 512'(idx));
    chk({tn, ".busy"}, 512'(bus.miss_ready_o), 512'd0);
    @(negedge clk_i);
    bus.valid_vec_i = vvec;
    #1;
    chk({tn, ".upd_repl"}, 512'(bus.update_repl_o), 512'd1);
    chk({tn, ".repl_vec"}, 512'(bus.repl_valid_vec_o), 512'(vvec));
    @(negedge clk_i);
    bus.valid_vec_i = '0;
  endtask

  task automatic run_miss(input vec_t v, input int n);
    logic [511:0] data;
    logic [11:0]  tagn;
    string        tn;
    int           lat;
    tn   = $sformatf("v%0d", n);
    tagn = 12'(n + 1);
    data = {16{tagn, v.tag}};
    to_mem_req(v.idx, v.tag, v.vvec, tn);
    lat = 3;
    for (int s = 0; s < v.stall; s++) begin
      bus.mem_req_ready_i = 1'b0;
      #1;
      chk({tn, ".req_hold"}, 512'(bus.mem_req_valid_o), 512'd1);
      chk({tn, ".addr_hold"}, 512'(bus.mem_req_addr_o), 512'(v.exp_addr));
      @(negedge clk_i);
      lat++;
    end
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk({tn, ".req_valid"}, 512'(bus.mem_req_valid_o), 512'd1);
    chk({tn, ".addr"}, 512'(bus.mem_req_addr_o), 512'(v.exp_addr));
    @(negedge clk_i);
    lat++;
    bus.mem_req_ready_i = 1'b0;
    #1 chk({tn, ".one_req"}, 512'(bus.mem_req_valid_o), 512'd0);
    for (int d = 0; d < v.delay; d++) begin
      #1 chk({tn, ".no_wr_wait"}, 512'(bus.wr_en_o), 512'd0);
      @(negedge clk_i);
      lat++;
    end
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = data;
    bus.mem_rsp_err_i   = v.err;
    #1 chk({tn, ".err_pulse"}, 512'(bus.refill_err_o), 512'(v.err));
    @(negedge clk_i);
    lat++;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    bus.mem_rsp_err_i   = 1'b0;
    #1;
    if (!v.err) begin
      chk({tn, ".wr_en"}, 512'(bus.wr_en_o), 512'd1);
      chk({tn, ".latency"}, 512'(lat), 512'(v.exp_lat));
      chk({tn, ".wr_way"}, 512'(bus.wr_way_o), 512'(v.exp_way));
      chk({tn, ".wr_idx"}, 512'(bus.wr_idx_o), 512'(v.idx));
      chk({tn, ".wr_tag"}, 512'(bus.wr_tag_o), 512'(v.tag));
      chk({tn, ".wr_data"}, bus.wr_data_o, data);
      chk({tn, ".done"}, 512'(bus.refill_done_o), 512'd1);
      @(negedge clk_i);
      #1;
    end
    chk({tn, ".idle_ready"}, 512'(bus.miss_ready_o), 512'd1);
    chk({tn, ".idle_wr_en"}, 512'(bus.wr_en_o), 512'd0);
    chk({tn, ".idle_done"}, 512'(bus.refill_done_o), 512'd0);
    chk({tn, ".idle_err"}, 512'(bus.refill_err_o), 512'd0);
    $display("txn %s idx=%0d tag=%05h vvec=%b stall=%0d delay=%0d err=%0d lat=%0d", tn, v.idx, v.tag,
             v.vvec, v.stall, v.delay, v.err, lat);
  endtask

  task automatic chk_all_quiet(input string tn);
    chk({tn, ".ready"}, 512'(bus.miss_ready_o), 512'd1);
    chk({tn, ".rd_en"}, 512'(bus.valid_rd_en_o), 512'd0);
    chk({tn, ".rd_idx"}, 512'(bus.valid_rd_idx_o), 512'd0);
    chk({tn, ".upd"}, 512'(bus.update_repl_o), 512'd0);
    chk({tn, ".repl_vec"}, 512'(bus.repl_valid_vec_o), 512'd0);
    chk({tn, ".req"}, 512'(bus.mem_req_valid_o), 512'd0);
    chk({tn, ".addr"}, 512'(bus.mem_req_addr_o), 512'd0);
    chk({tn, ".wr_en"}, 512'(bus.wr_en_o), 512'd0);
    chk({tn, ".wr_way"}, 512'(bus.wr_way_o), 512'd0);
    chk({tn, ".done"}, 512'(bus.refill_done_o), 512'd0);
    chk({tn, ".err"}, 512'(bus.refill_err_o), 512'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    tbl[0] = '{idx: 6'd5,  tag: 20'hABCDE, vvec: 4'b1011, stall: 0, delay: 0, err: 1'b0,
               exp_addr: 32'hABCDE140, exp_way: 4'b0100, exp_lat: 5};
    tbl[1] = '{idx: 6'd1,  tag: 20'h11111, vvec: 4'b1111, stall: 0, delay: 0, err: 1'b0,
               exp_addr: 32'h11111040, exp_way: 4'b0001, exp_lat: 5};
    tbl[2] = '{idx: 6'd2,  tag: 20'h22222, vvec: 4'b1111, stall: 0, delay: 0, err: 1'b0,
               exp_addr: 32'h22222080, exp_way: 4'b0010, exp_lat: 5};
    tbl[3] = '{idx: 6'd2,  tag: 20'h33333, vvec: 4'b1111, stall: 0, delay: 0, err: 1'b0,
               exp_addr: 32'h33333080, exp_way: 4'b0100, exp_lat: 5};
    tbl[4] = '{idx: 6'd3,  tag: 20'h12345, vvec: 4'b0111, stall: 7, delay: 0, err: 1'b0,
               exp_addr: 32'h123450C0, exp_way: 4'b1000, exp_lat: 12};
    tbl[5] = '{idx: 6'd63, tag: 20'hFFFFF, vvec: 4'b0000, stall: 0, delay: 0, err: 1'b1,
               exp_addr: 32'hFFFFFFC0, exp_way: 4'b0001, exp_lat: 0};
    tbl[6] = '{idx: 6'd0,  tag: 20'h00001, vvec: 4'b1111, stall: 0, delay: 3, err: 1'b0,
               exp_addr: 32'h00001000, exp_way: 4'b1000, exp_lat: 8};

    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk_all_quiet("reset");

    for (int n = 0; n < 7; n++) begin
      run_miss(tbl[n], n);
    end

    // Kill in SEL_WAY: back to IDLE, memory never sees a request.
    @(negedge clk_i);
    bus.miss_valid_i = 1'b1;
    bus.miss_idx_i   = 6'd7;
    bus.miss_tag_i   = 20'h0CAFE;
    @(negedge clk_i);
    bus.miss_valid_i = 1'b0;
    @(negedge clk_i);
    bus.valid_vec_i = 4'b0111;
    bus.kill_i      = 1'b1;
    #1 chk("kill_sel.upd", 512'(bus.update_repl_o), 512'd1);
    @(negedge clk_i);
    bus.kill_i      = 1'b0;
    bus.valid_vec_i = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("kill_sel.no_req", 512'(bus.mem_req_valid_o), 512'd0);
      chk("kill_sel.ready", 512'(bus.miss_ready_o), 512'd1);
      @(negedge clk_i);
    end
    $display("txn kill_sel idx=7 tag=0cafe");

    // Kill in MEM_WAIT, response four cycles later is drained silently.
    to_mem_req(6'd9, 20'h0D00D, 4'b0111, "kill_wait");
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    bus.mem_req_ready_i = 1'b0;
    bus.kill_i = 1'b1;
    @(negedge clk_i);
    bus.kill_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("kill_wait.busy", 512'(bus.miss_ready_o), 512'd0);
      @(negedge clk_i);
    end
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = {16{32'hDEADBEEF}};
    #1 chk("kill_wait.rsp_err", 512'(bus.refill_err_o), 512'd0);
    @(negedge clk_i);
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("kill_wait.no_wr", 512'(bus.wr_en_o), 512'd0);
      chk("kill_wait.no_done", 512'(bus.refill_done_o), 512'd0);
      chk("kill_wait.ready", 512'(bus.miss_ready_o), 512'd1);
      @(negedge clk_i);
    end
    $display("txn kill_wait idx=9 tag=0d00d");

    // Reset in MEM_WAIT, then a fresh refill must complete normally.
    to_mem_req(6'd4, 20'h0F00F, 4'b0011, "rst_wait");
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    bus.mem_req_ready_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk_all_quiet("rst_wait");
    $display("txn rst_wait idx=4 tag=0f00f");
    rv = '{idx: 6'd10, tag: 20'h0BEEF, vvec: 4'b1111, stall: 0, delay: 0, err: 1'b0,
           exp_addr: 32'h0BEEF280, exp_way: 4'b0001, exp_lat: 5};
    run_miss(rv, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
